// File: rtl/mux2_sel_arbiter.sv
// Two-requester round-robin arbiter driving the 2:1 mux select.
// Grants are held until done, request drop or MAX_HOLD; a GAP cycle follows.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   req1    source in1 requests the mux
//   req2    source in2 requests the mux
//   done    owner releases the grant (ignored outside a grant)
//   sel     mux select, 0 = in1, 1 = in2 (frozen while busy)
//   gnt1    grant to in1
//   gnt2    grant to in2
//   busy    a grant is active
//   timeout one-cycle pulse when MAX_HOLD revokes a grant
module mux2_sel_arbiter #(
  parameter int CNT_W    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req1,
  input  logic req2,
  input  logic done,
  output logic sel,
  output logic gnt1,
  output logic gnt2,
  output logic busy,
  output logic timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GNT1,
    GNT2,
    GAP
  } state_t;

  localparam bit TO_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic             gnt1_q, gnt1_d;
  logic             gnt2_q, gnt2_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic in_grant;
  logic own_req;
  logic rel;
  logic hit;
  logic exit_grant;

  assign in_grant   = (state_q == GNT1) || (state_q == GNT2);
  assign own_req    = (state_q == GNT2) ? req2 : req1;
  assign rel        = done || !own_req;
  assign hit        = TO_EN && (hold_q == HOLD_LAST);
  assign exit_grant = rel || hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      gnt1_q    <= 1'b0;
      gnt2_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      gnt1_q    <= gnt1_d;
      gnt2_q    <= gnt2_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  // last_q holds the select value of the previous owner, so a tie
  // goes to in1 when last_q=1 and to in2 when last_q=0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req1 && (!req2 || last_q)) begin
          state_d = GNT1;
        end else if (req2) begin
          state_d = GNT2;
        end
      end
      GNT1, GNT2: begin
        if (exit_grant) begin
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead from the next state so that
  // every port comes straight from a flop.
  always_comb begin
    hold_d    = '0;
    last_d    = last_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    gnt1_d    = (state_d == GNT1);
    gnt2_d    = (state_d == GNT2);
    busy_d    = gnt1_d || gnt2_d;
    unique case (1'b1)
      in_grant: begin
        if (exit_grant) begin
          last_d    = (state_q == GNT2);
          timeout_d = hit && !rel;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end else begin
          hold_d = hold_q;
        end
      end
      (state_q == IDLE): begin
        if (state_d == GNT1) begin
          sel_d = 1'b0;
        end else if (state_d == GNT2) begin
          sel_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign sel     = sel_q;
  assign gnt1    = gnt1_q;
  assign gnt2    = gnt2_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux2_sel_arbiter.sv
// Bench for mux2_sel_arbiter: three configurations driven in parallel,
// checked against a per-instance grant model, vector table and sequences.
module tb_mux2_sel_arbiter;

  localparam int N = 3;

  int mh [N] = '{16, 4, 0};

  logic clk = 1'b0;
  logic rst;
  logic req1, req2, done;
  logic in1, in2;
  logic [N-1:0] sel, gnt1, gnt2, busy, tmo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux2_sel_arbiter #(.CNT_W(8), .MAX_HOLD(16)) u_def (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2), .done(done),
    .sel(sel[0]), .gnt1(gnt1[0]), .gnt2(gnt2[0]),
    .busy(busy[0]), .timeout(tmo[0])
  );

  mux2_sel_arbiter #(.CNT_W(8), .MAX_HOLD(4)) u_t4 (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2), .done(done),
    .sel(sel[1]), .gnt1(gnt1[1]), .gnt2(gnt2[1]),
    .busy(busy[1]), .timeout(tmo[1])
  );

  mux2_sel_arbiter #(.CNT_W(3), .MAX_HOLD(0)) u_nt (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2), .done(done),
    .sel(sel[2]), .gnt1(gnt1[2]), .gnt2(gnt2[2]),
    .busy(busy[2]), .timeout(tmo[2])
  );

  // Reference: owner id (0 none, 1 in1, 2 in2), cycles already granted,
  // pending turnaround cycle, last owner id, current select, timeout pulse.
  int m_own [N];
  int m_gc  [N];
  int m_gap [N];
  int m_last[N];
  bit m_sel [N];
  bit m_to  [N];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < N; k++) begin
      m_own[k]  = 0;
      m_gc[k]   = 0;
      m_gap[k]  = 0;
      m_last[k] = 2;
      m_sel[k]  = 1'b0;
      m_to[k]   = 1'b0;
    end
  endtask

  task automatic m_edge();
    bit rq, rl, lim;
    for (int k = 0; k < N; k++) begin
      m_to[k] = 1'b0;
      if (m_own[k] != 0) begin
        rq  = (m_own[k] == 1) ? req1 : req2;
        rl  = done || !rq;
        lim = (mh[k] != 0) && (m_gc[k] >= mh[k]);
        if (rl || lim) begin
          m_to[k]   = !rl;
          m_last[k] = m_own[k];
          m_own[k]  = 0;
          m_gap[k]  = 1;
        end else begin
          m_gc[k]++;
        end
      end else if (m_gap[k] != 0) begin
        m_gap[k] = 0;
      end else begin
        if (req1 && req2) m_own[k] = (m_last[k] == 1) ? 2 : 1;
        else if (req1) m_own[k] = 1;
        else if (req2) m_own[k] = 2;
        if (m_own[k] != 0) begin
          m_gc[k]  = 1;
          m_sel[k] = (m_own[k] == 2);
        end
      end
    end
  endtask

  function automatic int act_of(input int k);
    return int'({sel[k], gnt1[k], gnt2[k], busy[k], tmo[k]});
  endfunction

  task automatic cmp_model();
    int e;
    for (int k = 0; k < N; k++) begin
      e = int'({m_sel[k], m_own[k] == 1, m_own[k] == 2,
                m_own[k] != 0, m_to[k]});
      chk($sformatf("model_u%0d_{sel,g1,g2,busy,to}", k), act_of(k), e);
    end
  endtask

  task automatic step(input bit r1, input bit r2, input bit d);
    req1 = r1;
    req2 = r2;
    done = d;
    in1  = ~in1;
    in2  = ~in1;
    @(posedge clk);
    m_edge();
    #1;
    cmp_model();
  endtask

  // Called at posedge+1: reset lands mid-cycle, outputs must clear at once.
  task automatic reset_mid();
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("async_rst_u%0d", k), act_of(k), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Select must not move during a grant and the mux must pass the owner.
  logic [N-1:0] sel_p = '0;
  logic [N-1:0] busy_p = '0;
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (busy_p[k] && busy[k]) chk($sformatf("sel_stable_u%0d", k),
                                    sel[k], sel_p[k]);
      if (gnt1[k]) chk($sformatf("mux_in1_u%0d", k),
                       sel[k] ? in2 : in1, in1);
      if (gnt2[k]) chk($sformatf("mux_in2_u%0d", k),
                       sel[k] ? in2 : in1, in2);
    end
    sel_p  = sel;
    busy_p = busy;
  end

  typedef struct {
    bit       r1;
    bit       r2;
    bit       d;
    bit [4:0] exp;
  } vec_t;

  vec_t tv [14];

  initial begin
    // {sel, gnt1, gnt2, busy, timeout} after each edge; tie alternation.
    tv[0]  = '{1'b1, 1'b1, 1'b0, 5'b01010};
    tv[1]  = '{1'b1, 1'b1, 1'b1, 5'b00000};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 5'b00000};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 5'b10110};
    tv[4]  = '{1'b1, 1'b1, 1'b0, 5'b10110};
    tv[5]  = '{1'b1, 1'b1, 1'b1, 5'b10000};
    tv[6]  = '{1'b1, 1'b1, 1'b0, 5'b10000};
    tv[7]  = '{1'b1, 1'b1, 1'b0, 5'b01010};
    tv[8]  = '{1'b1, 1'b1, 1'b1, 5'b00000};
    tv[9]  = '{1'b1, 1'b1, 1'b0, 5'b00000};
    tv[10] = '{1'b1, 1'b1, 1'b0, 5'b10110};
    tv[11] = '{1'b0, 1'b0, 1'b1, 5'b10000};
    tv[12] = '{1'b0, 1'b0, 1'b0, 5'b10000};
    tv[13] = '{1'b0, 1'b0, 1'b0, 5'b10000};

    rst  = 1'b1;
    req1 = 1'b0;
    req2 = 1'b0;
    done = 1'b0;
    in1  = 1'b0;
    in2  = 1'b1;
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    cmp_model();
    rst = 1'b0;

    // Reset mid-grant with req1 held, then regrant one edge later.
    step(1, 0, 0);
    chk("first_gnt1", gnt1[0], 1);
    step(1, 0, 0);
    reset_mid();
    step(1, 0, 0);
    chk("post_rst_gnt1", gnt1[0], 1);
    chk("post_rst_sel", sel[0], 0);
    reset_mid();
    step(0, 1, 0);
    chk("pre_rst_sel1", sel[0], 1);
    reset_mid();
    chk("rst_sel0", sel[0], 0);

    // Tie after reset and strict alternation.
    for (int i = 0; i < 14; i++) begin
      step(tv[i].r1, tv[i].r2, tv[i].d);
      for (int k = 0; k < N; k++) begin
        chk($sformatf("vec%0d_u%0d", i, k), act_of(k), int'(tv[i].exp));
      end
    end

    // Single requester on the default configuration.
    reset_mid();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0);
      chk("single_gnt2", gnt2[0], 1);
      chk("single_sel", sel[0], 1);
    end
    step(0, 1, 1);
    chk("single_done_gnt2", gnt2[0], 0);
    chk("single_done_sel", sel[0], 1);
    step(0, 0, 0);
    chk("single_gap_sel", sel[0], 1);
    step(0, 0, 0);
    chk("single_idle_sel", sel[0], 1);

    // Timeout with MAX_HOLD=4.
    reset_mid();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      chk("to_gnt1_high", gnt1[1], 1);
      chk("to_pulse_low", tmo[1], 0);
    end
    step(1, 0, 0);
    chk("to_gnt1_fall", gnt1[1], 0);
    chk("to_pulse", tmo[1], 1);
    step(1, 0, 0);
    chk("to_gap_pulse", tmo[1], 0);
    chk("to_gap_gnt1", gnt1[1], 0);
    step(1, 0, 0);
    chk("to_regrant", gnt1[1], 1);

    // done coinciding with the final hold cycle.
    reset_mid();
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    chk("sim_gnt1_c4", gnt1[1], 1);
    step(1, 0, 1);
    chk("sim_gnt1_rel", gnt1[1], 0);
    chk("sim_no_pulse", tmo[1], 0);

    // Random traffic in three bias phases, occasional async reset.
    reset_mid();
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 1000; i++) begin
        if ($urandom_range(0, 199) == 0) begin
          reset_mid();
        end else begin
          case (ph)
            0: step($urandom_range(0, 99) < 95, $urandom_range(0, 99) < 95,
                    $urandom_range(0, 99) < 1);
            1: step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60,
                    $urandom_range(0, 99) < 10);
            default: step($urandom_range(0, 99) < 80,
                          $urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 5);
          endcase
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
